// File: rtl/ysyx_22050612_pkg.sv
// Shared types and constants for the ysyx_22050612 instruction fetch slice.
package ysyx_22050612_pkg;

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_OUT   = 2'd1,
        S_WAIT  = 2'd2,
        S_FAULT = 2'd3
    } ifu_state_e;

    localparam logic [31:0] INST_NOP         = 32'h0000_0013;
    localparam logic [63:0] DEFAULT_RESET_PC = 64'h8000_0000;

endpackage

// File: rtl/ysyx_22050612_ifu_counter.sv
// Free-running instruction handoff counter; wraps modulo 2^WIDTH.
module ysyx_22050612_ifu_counter #(
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (en) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/ysyx_22050612_ifu.sv
// Single-outstanding instruction fetch unit: REQ -> OUT -> WAIT loop driven by commit.
// Optional misaligned-dnpc trap compiled in with IFU_ALIGN_CHECK_EN.
module ysyx_22050612_ifu
    import ysyx_22050612_pkg::*;
#(
    parameter int unsigned     XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [31:0]     inst,
    output logic [XLEN-1:0] inst_pc,
    input  logic            commit_valid,
    input  logic [XLEN-1:0] commit_dnpc,
    output logic            fetch_fault,
    output logic [63:0]     fetch_count
);

    ifu_state_e      state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst_pc_q;
    logic [31:0]     inst_q;
    logic            req_q;
    logic            valid_q;
`ifdef IFU_ALIGN_CHECK_EN
    logic            fault_q;
`endif

    // req_q/valid_q mirror the state so the port outputs come straight from flops.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_REQ;
            pc        <= RESET_PC;
            inst_q    <= INST_NOP;
            inst_pc_q <= RESET_PC;
            req_q     <= 1'b1;
            valid_q   <= 1'b0;
`ifdef IFU_ALIGN_CHECK_EN
            fault_q   <= 1'b0;
`endif
        end else begin
            case (state)
                S_REQ: begin
                    if (imem_ack) begin
                        inst_q    <= imem_rdata;
                        inst_pc_q <= pc;
                        req_q     <= 1'b0;
                        valid_q   <= 1'b1;
                        state     <= S_OUT;
                    end
                end
                S_OUT: begin
                    if (inst_ready) begin
                        valid_q <= 1'b0;
                        state   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (commit_valid) begin
`ifdef IFU_ALIGN_CHECK_EN
                        if (commit_dnpc[1:0] != 2'b00) begin
                            fault_q <= 1'b1;
                            state   <= S_FAULT;
                        end else
`endif
                        begin
                            pc    <= commit_dnpc;
                            req_q <= 1'b1;
                            state <= S_REQ;
                        end
                    end
                end
                default: begin
                    state <= S_FAULT;
                end
            endcase
        end
    end

    assign imem_req   = req_q;
    assign imem_addr  = pc;
    assign inst_valid = valid_q;
    assign inst       = inst_q;
    assign inst_pc    = inst_pc_q;

`ifdef IFU_ALIGN_CHECK_EN
    assign fetch_fault = fault_q;
`else
    assign fetch_fault = 1'b0;
`endif

    ysyx_22050612_ifu_counter #(
        .WIDTH (64)
    ) u_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (valid_q & inst_ready),
        .count (fetch_count)
    );

endmodule
